cordic_vectoring: RTL and testbench

Iterative CORDIC engine in vectoring mode: takes a signed Cartesian vector (xin, yin) and returns its gain-compensated magnitude and its angle, atan2(yin, xin). It is the inverse companion of the rotation-mode sin/cos CORDIC. It uses the same angle convention, where 2^32 corresponds to 360°, so its angle output can be fed straight back to the rotation block. One micro-rotation is done per clock behind a start/busy/done handshake, trading throughput for area.

---
 rtl/cordic_vectoring.sv | 144 ++++++++++++++
 tb/tb_cordic_vectoring.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: one micro-rotation per clock, returns the
// gain-compensated magnitude and atan2(yin, xin) with 2^32 = 360 degrees.
module cordic_vectoring (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] xin,
    input  logic [15:0] yin,
    output logic        busy,
    output logic        done,
    output logic [16:0] mag,
    output logic [31:0] angle
);
    localparam int ITER = 16;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FINISH} state_t;

    // round(atan(2^-i) * 2^32 / 360)
    localparam logic [31:0] ATAN [ITER] = '{
        32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
        32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
        32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
        32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D
    };

    state_t             state_q, state_d;
    logic signed [17:0] x_q, x_d, y_q, y_d;
    logic        [31:0] z_q, z_d;
    logic        [3:0]  i_q, i_d;
    logic               zero_q, zero_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic        [16:0] mag_q, mag_d;
    logic        [31:0] angle_q, angle_d;

    logic signed [17:0] xin_s, yin_s, x_sh, y_sh;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        zero_d  = zero_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        mag_d   = mag_q;
        angle_d = angle_q;
        // Widen before negating so -32768 negates exactly.
        xin_s   = {{2{xin[15]}}, xin};
        yin_s   = {{2{yin[15]}}, yin};
        x_sh    = x_q >>> i_q;
        y_sh    = y_q >>> i_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ITER;
                    busy_d  = 1'b1;
                    i_d     = 4'd0;
                    zero_d  = (xin == 16'd0) && (yin == 16'd0);
                    // Pre-rotate left-half-plane vectors by +/-90 degrees.
                    if (!xin[15]) begin
                        x_d = xin_s;
                        y_d = yin_s;
                        z_d = 32'h00000000;
                    end else if (!yin[15]) begin
                        x_d = yin_s;
                        y_d = -xin_s;
                        z_d = 32'h40000000;
                    end else begin
                        x_d = -yin_s;
                        y_d = xin_s;
                        z_d = 32'hC0000000;
                    end
                end
            end
            S_ITER: begin
                if (!y_q[17]) begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + ATAN[i_q];
                end else begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - ATAN[i_q];
                end
                i_d = i_q + 4'd1;
                if (i_q == 4'(ITER - 1)) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                // x * 0.59375 approximates 1/K; x is non-negative here.
                if (zero_q) begin
                    mag_d   = 17'd0;
                    angle_d = 32'd0;
                end else begin
                    mag_d   = 17'(x_q >>> 1) + 17'(x_q >>> 4) + 17'(x_q >>> 5);
                    angle_d = z_q;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mag_q   <= '0;
            angle_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mag_q   <= mag_d;
            angle_q <= angle_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign mag   = mag_q;
    assign angle = angle_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Table-driven bench for cordic_vectoring: expected results are queued at
// start and compared by a monitor when done pulses.
module tb_cordic_vectoring;
    logic        clock = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] xin, yin;
    logic        busy, done;
    logic [16:0] mag;
    logic [31:0] angle;

    cordic_vectoring dut (
        .clock (clock),
        .rst_n (rst_n),
        .start (start),
        .xin   (xin),
        .yin   (yin),
        .busy  (busy),
        .done  (done),
        .mag   (mag),
        .angle (angle)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [15:0] x;
        logic [15:0] y;
        int          emag;
        int          mtol;
        logic [31:0] eang;
        int          atol;
    } vec_t;

    vec_t tbl [9];
    vec_t sb [$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_cnt = 0;

    task automatic chk(input string nm, input bit ok, input longint act, input longint req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    endtask

    // Scoreboard monitor: one line per completed transaction.
    initial begin
        vec_t e;
        int   dm, da;
        forever begin
            @(posedge clock);
            #1;
            if (rst_n && done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1'b0, 1, 0);
                end else begin
                    e  = sb.pop_front();
                    dm = int'(mag) - e.emag;
                    da = int'(angle - e.eang);
                    if (dm < 0) dm = -dm;
                    if (da < 0) da = -da;
                    $display("txn %s x=%0d y=%0d mag=%0d angle=%08h", e.name,
                             $signed(e.x), $signed(e.y), mag, angle);
                    chk({e.name, "_mag"}, dm <= e.mtol, longint'(mag), longint'(e.emag));
                    chk({e.name, "_angle"}, da <= e.atol, longint'(angle), longint'(e.eang));
                end
            end
        end
    end

    task automatic run_vec(input vec_t v, input bit inject);
        int n;
        int busy_bad;
        xin   = v.x;
        yin   = v.y;
        start = 1'b1;
        sb.push_back(v);
        @(posedge clock);
        #1;
        start    = 1'b0;
        xin      = 16'($urandom);
        yin      = 16'($urandom);
        n        = 0;
        busy_bad = 0;
        while (!done && n < 40) begin
            if (!busy) busy_bad++;
            if (inject && (n == 2 || n == 9)) begin
                start = 1'b1;
                xin   = 16'hEC78;
                yin   = 16'd777;
            end else begin
                start = 1'b0;
            end
            @(posedge clock);
            #1;
            n++;
        end
        start = 1'b0;
        chk({v.name, "_latency"}, n == 17, n, 17);
        chk({v.name, "_busy_during"}, busy_bad == 0, busy_bad, 0);
        chk({v.name, "_busy_at_done"}, busy == 1'b0, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        tbl[0] = '{"x_pos",  16'd1000,  16'd0,     977,   3, 32'h00000000, 32'h00100000};
        tbl[1] = '{"y_pos",  16'd0,     16'd1000,  977,   3, 32'h40000000, 32'h00100000};
        tbl[2] = '{"q4_45",  16'd1000,  16'hFC18,  1383,  4, 32'hE0000000, 32'h00100000};
        tbl[3] = '{"x_neg",  16'hFC18,  16'd0,     977,   3, 32'h80000000, 32'h00100000};
        tbl[4] = '{"corner", 16'h8000,  16'h8000,  45313, 8, 32'hA0000000, 32'h00010000};
        tbl[5] = '{"zero",   16'd0,     16'd0,     0,     0, 32'h00000000, 0};
        tbl[6] = '{"q2_135", 16'hFC18,  16'd1000,  1383,  4, 32'h60000000, 32'h00100000};
        tbl[7] = '{"y_neg",  16'd0,     16'hFC18,  977,   3, 32'hC0000000, 32'h00100000};
        tbl[8] = '{"tri345", 16'd3000,  16'd4000,  4889,  4, 32'h25C80A1F, 32'h00100000};

        rst_n = 1'b0;
        start = 1'b0;
        xin   = '0;
        yin   = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_busy",  busy == 1'b0,   busy,  0);
        chk("reset_done",  done == 1'b0,   done,  0);
        chk("reset_mag",   mag == 17'd0,   mag,   0);
        chk("reset_angle", angle == 32'd0, angle, 0);
        rst_n = 1'b1;
        @(posedge clock);
        #1;

        // Back-to-back: each new start lands in the cycle right after done.
        for (int k = 0; k < 9; k++) run_vec(tbl[k], 1'b0);

        // Starts during a conversion must be ignored.
        repeat (2) @(posedge clock);
        #1;
        d0 = done_cnt;
        run_vec(tbl[2], 1'b1);
        repeat (20) @(posedge clock);
        #1;
        chk("ignored_starts_one_done", (done_cnt - d0) == 1, done_cnt - d0, 1);

        // Asynchronous reset in the middle of the iterations.
        xin   = 16'd3000;
        yin   = 16'd4000;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_busy",  busy == 1'b0,   busy,  0);
        chk("midreset_done",  done == 1'b0,   done,  0);
        chk("midreset_mag",   mag == 17'd0,   mag,   0);
        chk("midreset_angle", angle == 32'd0, angle, 0);
        repeat (2) @(posedge clock);
        #1;
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (25) @(posedge clock);
        #1;
        chk("no_done_after_reset", done_cnt == d0, done_cnt - d0, 0);
        run_vec(tbl[8], 1'b0);
        repeat (3) @(posedge clock);
        #1;
        chk("scoreboard_drained", sb.size() == 0, sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
